// File: rtl/eth_rmii_tx.sv
// RMII transmit path: frames a valid/ready byte stream with preamble/SFD, zero padding,
// CRC-32 FCS and inter-frame gap, emitting one TXD dibit per 50 MHz clock.
module eth_rmii_tx #(
   parameter int MIN_FRAME      = 60,
   parameter int IFG_BYTES      = 12,
   parameter int PREAMBLE_BYTES = 7
) (
   input  logic       clk50,
   input  logic       reset,
   input  logic [7:0] data,
   input  logic       valid,
   input  logic       eop,
   output logic       ready,
   output logic [1:0] tx,
   output logic       txen,
   output logic       busy,
   output logic       done,
   output logic       underrun
);

   typedef enum logic [2:0] {
      S_IDLE, S_PREAMBLE, S_DATA, S_PAD, S_FCS, S_IFG
   } state_t;

   localparam logic [31:0] CRC_POLY = 32'hEDB88320;
   localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES * 4 - 1);
   localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_BYTES);
   localparam logic [15:0] MIN_LEN  = 16'(MIN_FRAME);

   state_t      r_state, w_state;
   logic [1:0]  r_k, w_k;
   logic [15:0] r_cnt, w_cnt;
   logic [7:0]  r_byte, w_byte;
   logic        r_last, w_last;
   logic [31:0] r_crc, w_crc, w_crc_upd;
   logic [1:0]  r_tx, w_tx, w_fcs_idx;
   logic        r_txen, w_txen;
   logic        r_ready, w_ready;
   logic        r_busy, w_busy;
   logic        r_done, w_done;
   logic        r_underrun, w_underrun;

   // Reflected CRC-32 advanced by one dibit, bit 0 first on the wire.
   function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
      logic [31:0] v;
      v = c;
      for (int i = 0; i < 2; i++)
         v = (v[0] ^ d[i]) ? ((v >> 1) ^ CRC_POLY) : (v >> 1);
      return v;
   endfunction

   assign w_crc_upd = crc_dibit(r_crc, r_byte[{r_k, 1'b0} +: 2]);
   assign w_fcs_idx = r_cnt[1:0] + 2'd1;

   // Registers describe what is on the wire this clock; the next-state logic
   // decides what the wire carries after the coming edge.
   always_comb begin
      w_state    = r_state;
      w_k        = r_k + 2'd1;
      w_cnt      = r_cnt;
      w_byte     = r_byte;
      w_last     = r_last;
      w_crc      = r_crc;
      w_txen     = r_txen;
      w_underrun = 1'b0;
      if (r_state == S_DATA || r_state == S_PAD)
         w_crc = w_crc_upd;

      case (r_state)
         S_IDLE: begin
            w_k = 2'd0;
            if (valid) begin
               w_state = S_PREAMBLE;
               w_cnt   = 16'd0;
               w_byte  = (PRE_LAST == 16'd0) ? 8'hD5 : 8'h55;
               w_crc   = 32'hFFFF_FFFF;
               w_txen  = 1'b1;
            end
         end
         S_PREAMBLE, S_DATA, S_PAD: begin
            if (r_k == 2'd3) begin
               if (r_ready) begin
                  if (valid) begin
                     w_state = S_DATA;
                     w_byte  = data;
                     w_last  = eop;
                     w_cnt   = (r_state == S_PREAMBLE) ? 16'd1 : r_cnt + 16'd1;
                  end else begin
                     w_state    = S_IFG;
                     w_k        = 2'd0;
                     w_cnt      = 16'd0;
                     w_txen     = 1'b0;
                     w_underrun = 1'b1;
                  end
               end else if (r_state == S_PREAMBLE) begin
                  w_cnt  = r_cnt + 16'd1;
                  w_byte = (r_cnt + 16'd1 == PRE_LAST) ? 8'hD5 : 8'h55;
               end else if (r_cnt < MIN_LEN) begin
                  w_state = S_PAD;
                  w_cnt   = r_cnt + 16'd1;
                  w_byte  = 8'h00;
               end else begin
                  w_state = S_FCS;
                  w_cnt   = 16'd0;
                  w_byte  = ~w_crc_upd[7:0];
               end
            end
         end
         S_FCS: begin
            if (r_k == 2'd3) begin
               if (r_cnt == 16'd3) begin
                  w_state = S_IFG;
                  w_k     = 2'd0;
                  w_cnt   = 16'd0;
                  w_txen  = 1'b0;
               end else begin
                  w_cnt  = r_cnt + 16'd1;
                  w_byte = ~r_crc[{w_fcs_idx, 3'b000} +: 8];
               end
            end
         end
         S_IFG: begin
            w_k = 2'd0;
            if (r_cnt == IFG_LAST)
               w_state = S_IDLE;
            else
               w_cnt = r_cnt + 16'd1;
         end
         default: begin
            w_state = S_IDLE;
            w_k     = 2'd0;
            w_txen  = 1'b0;
         end
      endcase

      w_tx    = w_txen ? w_byte[{w_k, 1'b0} +: 2] : 2'b00;
      w_ready = (w_k == 2'd3) &&
                ((w_state == S_PREAMBLE && w_cnt == PRE_LAST) ||
                 (w_state == S_DATA && !w_last));
      w_done  = (w_state == S_FCS) && (w_cnt == 16'd3) && (w_k == 2'd3);
      // A pending frame keeps busy up through the IDLE sample clock.
      w_busy  = (w_state != S_IDLE) || valid;
   end

   always_ff @(posedge clk50) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_k        <= 2'd0;
         r_cnt      <= 16'd0;
         r_last     <= 1'b0;
         r_crc      <= 32'hFFFF_FFFF;
         r_tx       <= 2'b00;
         r_txen     <= 1'b0;
         r_ready    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_k        <= w_k;
         r_cnt      <= w_cnt;
         r_last     <= w_last;
         r_crc      <= w_crc;
         r_tx       <= w_tx;
         r_txen     <= w_txen;
         r_ready    <= w_ready;
         r_busy     <= w_busy;
         r_done     <= w_done;
         r_underrun <= w_underrun;
      end
   end

   always_ff @(posedge clk50)
      r_byte <= w_byte;

   assign tx       = r_tx;
   assign txen     = r_txen;
   assign ready    = r_ready;
   assign busy     = r_busy;
   assign done     = r_done;
   assign underrun = r_underrun;

endmodule

// File: tb/tb_eth_rmii_tx.sv
// Bench for eth_rmii_tx: a MIN_FRAME=0 instance and a default instance share stimulus;
// a dibit monitor decodes the selected one against a scoreboard of expected wire bytes.
module tb_eth_rmii_tx;

   logic       clk;
   logic       reset;
   logic [7:0] data;
   logic       valid;
   logic       eop;

   logic       a_ready, a_txen, a_busy, a_done, a_underrun;
   logic [1:0] a_tx;
   logic       b_ready, b_txen, b_busy, b_done, b_underrun;
   logic [1:0] b_tx;

   logic       sel;
   logic       ready_s, txen_s, busy_s, done_s, underrun_s;
   logic [1:0] tx_s;

   eth_rmii_tx #(.MIN_FRAME(0), .IFG_BYTES(12), .PREAMBLE_BYTES(7)) dut_a (
      .clk50(clk), .reset(reset), .data(data), .valid(valid), .eop(eop),
      .ready(a_ready), .tx(a_tx), .txen(a_txen), .busy(a_busy),
      .done(a_done), .underrun(a_underrun)
   );

   eth_rmii_tx dut_b (
      .clk50(clk), .reset(reset), .data(data), .valid(valid), .eop(eop),
      .ready(b_ready), .tx(b_tx), .txen(b_txen), .busy(b_busy),
      .done(b_done), .underrun(b_underrun)
   );

   assign ready_s    = sel ? b_ready    : a_ready;
   assign tx_s       = sel ? b_tx       : a_tx;
   assign txen_s     = sel ? b_txen     : a_txen;
   assign busy_s     = sel ? b_busy     : a_busy;
   assign done_s     = sel ? b_done     : a_done;
   assign underrun_s = sel ? b_underrun : a_underrun;

   initial clk = 1'b0;
   always #10 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] exp_q [$];
   int         len_q [$];
   bit mon_en = 1'b0;
   bit abort  = 1'b0;
   int last_gap = 0;
   bit last_gap_busy = 1'b0;

   typedef struct {
      bit sel;
      int len;
      int pat;
      int exp_txen;
   } vec_t;
   vec_t vecs [6];

   task automatic check(input bit ok, input string name, input int act, input int exp);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {24'd0, b};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   // Monitor: rebuilds bytes from dibits and checks per-frame properties.
   initial begin
      logic [7:0] sh, e;
      int nd, run, done_at, done_cnt, since, gap;
      bit ur_seen, gap_busy;
      nd = 0; run = 0; done_at = 0; done_cnt = 0; since = 100; gap = 0;
      ur_seen = 0; gap_busy = 1; sh = 8'h00;
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            nd = 0; run = 0; done_cnt = 0; done_at = 0; ur_seen = 0; gap = 0; since = 100;
            gap_busy = 1;
         end else begin
            if (underrun_s) ur_seen = 1;
            if (ready_s) begin
               check(since >= 3 && txen_s, "ready_spacing", since, 3);
               since = 0;
            end else begin
               since++;
            end
            if (txen_s) begin
               if (run == 0) begin
                  last_gap = gap;
                  last_gap_busy = gap_busy;
               end
               run++;
               if (done_s) begin
                  done_cnt++;
                  done_at = run;
               end
               sh = {tx_s, sh[7:2]};
               nd++;
               if (nd == 4) begin
                  nd = 0;
                  if (exp_q.size() == 0) begin
                     check(1'b0, "unexpected_byte", int'(sh), 0);
                  end else begin
                     e = exp_q.pop_front();
                     check(sh == e, "wire_byte", int'(sh), int'(e));
                  end
               end
            end else begin
               if (run > 0) begin
                  if (len_q.size() == 0) begin
                     check(1'b0, "unexpected_frame", run, 0);
                  end else begin
                     int el;
                     el = len_q.pop_front();
                     check(run == el, "txen_len", run, el);
                  end
                  check(done_cnt == 1 && done_at == run, "done_pos", done_at, run);
                  check(!ur_seen, "no_underrun", int'(ur_seen), 0);
                  check(nd == 0, "dibit_align", nd, 0);
                  run = 0; nd = 0; done_cnt = 0; done_at = 0; ur_seen = 0;
                  gap = 0; gap_busy = 1;
               end
               gap++;
               if (!busy_s) gap_busy = 0;
            end
         end
      end
   end

   task automatic drive_frame(input int len, input int pat, input bit gaps, input bit hold,
                              input int drop_at, input int exp_txen);
      logic [7:0] pl [$];
      logic [7:0] b;
      logic [31:0] c, fcs;
      int minf, idx, guard;
      minf = sel ? 60 : 0;
      for (int i = 0; i < len; i++)
         pl.push_back(pat == 0 ? 8'(8'h31 + i) : (pat == 1 ? 8'($urandom) : 8'(i)));
      if (mon_en) begin
         for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
         exp_q.push_back(8'hD5);
         c = 32'hFFFF_FFFF;
         for (int i = 0; i < len || i < minf; i++) begin
            b = (i < len) ? pl[i] : 8'h00;
            exp_q.push_back(b);
            c = crc_byte(c, b);
         end
         fcs = (pat == 0) ? 32'hCBF43926 : ~c;
         for (int i = 0; i < 4; i++) exp_q.push_back(fcs[8*i +: 8]);
         len_q.push_back(exp_txen);
      end
      idx = 0;
      guard = 0;
      data = pl[0];
      eop = (len == 1);
      valid = 1'b1;
      while (idx < len && !abort && guard < 20000) begin
         @(negedge clk);
         guard++;
         if (abort) break;
         if (ready_s) begin
            if (idx == drop_at) begin
               valid = 1'b0;
               @(posedge clk);
               #1;
               break;
            end
            valid = 1'b1;
            @(posedge clk);
            #1;
            idx++;
            if (idx < len) begin
               data = pl[idx];
               eop = (idx == len - 1);
            end
         end else if (gaps) begin
            valid = ($urandom_range(0, 3) != 0);
         end
      end
      check(guard < 20000, "drive_timeout", guard, 20000);
      valid = hold;
      eop = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int g;
      g = 0;
      while ((exp_q.size() != 0 || len_q.size() != 0 || busy_s || txen_s) && g < 5000) begin
         @(negedge clk);
         g++;
      end
      check(g < 5000, tag, g, 5000);
   endtask

   initial begin
      int bc, urc, g;
      bit txen_seen;
      reset = 1'b1; valid = 1'b0; data = 8'h00; eop = 1'b0; sel = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check({a_tx, a_txen, a_ready, a_busy, a_done, a_underrun} == 7'd0, "reset_a",
            int'({a_tx, a_txen, a_ready, a_busy, a_done, a_underrun}), 0);
      check({b_tx, b_txen, b_ready, b_busy, b_done, b_underrun} == 7'd0, "reset_b",
            int'({b_tx, b_txen, b_ready, b_busy, b_done, b_underrun}), 0);
      @(posedge clk);
      #1 reset = 1'b0;
      mon_en = 1'b1;

      vecs[0] = '{1'b0, 9,  0, 84};
      vecs[1] = '{1'b1, 14, 1, 288};
      vecs[2] = '{1'b1, 1,  1, 288};
      vecs[3] = '{1'b1, 60, 2, 288};
      vecs[4] = '{1'b1, 61, 1, 292};
      vecs[5] = '{1'b1, 64, 2, 304};
      for (int i = 0; i < 6; i++) begin
         if (vecs[i].sel != sel) begin
            mon_en = 1'b0;
            reset = 1'b1;
            repeat (2) @(posedge clk);
            #1 reset = 1'b0;
            sel = vecs[i].sel;
            mon_en = 1'b1;
         end
         drive_frame(vecs[i].len, vecs[i].pat, 1'b0, 1'b0, -1, vecs[i].exp_txen);
         wait_idle("vec_idle");
      end

      // Back-to-back frames with valid held high.
      drive_frame(64, 1, 1'b0, 1'b1, -1, 304);
      drive_frame(64, 2, 1'b0, 1'b0, -1, 304);
      wait_idle("b2b_idle");
      check(last_gap == 49, "b2b_gap", last_gap, 49);
      check(last_gap_busy, "b2b_busy", int'(last_gap_busy), 1);

      // Underrun at byte 20.
      mon_en = 1'b0;
      drive_frame(40, 1, 1'b0, 1'b0, 20, 0);
      @(negedge clk);
      check(underrun_s && !txen_s, "underrun_pulse", int'({underrun_s, txen_s}), 2);
      bc = 0; urc = 0; txen_seen = 0;
      for (int k = 0; k < 200; k++) begin
         if (!busy_s) break;
         bc++;
         if (txen_s) txen_seen = 1;
         if (underrun_s) urc++;
         @(negedge clk);
      end
      check(bc == 48, "underrun_busy", bc, 48);
      check(urc == 1, "underrun_once", urc, 1);
      check(!txen_seen, "underrun_no_fcs", int'(txen_seen), 0);

      // Reset at clock 100 of a frame.
      abort = 1'b0;
      fork
         drive_frame(200, 1, 1'b0, 1'b0, -1, 0);
         begin
            g = 0;
            while (!txen_s && g < 100) begin
               @(negedge clk);
               g++;
            end
            check(g < 100, "mid_reset_start", g, 100);
            repeat (99) @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            check(!txen_s && !ready_s, "mid_reset_outputs", int'({txen_s, ready_s}), 0);
            abort = 1'b1;
         end
      join
      @(posedge clk);
      #1 reset = 1'b0;
      abort = 1'b0;
      mon_en = 1'b1;
      drive_frame(14, 1, 1'b0, 1'b0, -1, 288);
      wait_idle("post_reset_idle");

      // Long frames with random valid gaps outside ready clocks.
      for (int p = 0; p < 5; p++) begin
         drive_frame(277, 1, 1'b1, 1'b0, -1, 1156);
         wait_idle("gap_idle");
      end

      check(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/eth_rmii_tx.md
Name: eth_rmii_tx

Overview:
- Transmit-side counterpart of the RMII receive path; one instance per PHY port, entirely in the 50 MHz RMII domain.
- Accepts a per-byte frame stream (valid/ready plus end-of-packet marker) and emits RMII TXD dibits with TX_EN.
- Generates preamble and SFD, pads short frames, appends the Ethernet FCS and enforces the inter-frame gap.
- Feeds from a playback/DMA block or an internal packet generator, symmetric to the capture path.

Parameters:
- MIN_FRAME, 60: minimum payload bytes before FCS; shorter frames are zero-padded; 0 disables padding.
- IFG_BYTES, 12: inter-frame gap in byte times; TX_EN is low for IFG_BYTES*4 clocks after every frame.
- PREAMBLE_BYTES, 7: count of 0x55 bytes sent before the 0xD5 SFD.

Ports:
- clk50 input 1: 50 MHz RMII reference clock; the only clock.
- reset input 1: synchronous, active-high.
- data input 8: frame byte, destination MAC first.
- valid input 1: data/eop are valid.
- eop input 1: qualifies data as the last byte of the frame.
- ready output 1: byte accepted on a clock edge where valid&&ready.
- tx output 2: RMII TXD[1:0].
- txen output 1: RMII TX_EN.
- busy output 1: high from frame start until the end of the IFG.
- done output 1: one-cycle pulse on the last FCS dibit clock.
- underrun output 1: one-cycle pulse when a frame is aborted.

Behaviour:
- Output timing: all outputs are registered.
- Reset values: tx=0, txen=0, ready=0, busy=0, done=0, underrun=0; state IDLE; CRC=0xFFFFFFFF.
- Reset mid-frame: txen drops on the next edge and no further dibits are sent.
- Data rate: one dibit per clock (100 Mb/s), LSB dibit first, so each byte takes 4 clocks (dibit index k=0..3).
- States: IDLE, PREAMBLE, DATA, PAD, FCS, IFG.
  - IDLE: ready=0. valid=1 sampled moves to PREAMBLE; txen rises the following clock. The byte is not consumed.
  - PREAMBLE: PREAMBLE_BYTES of 0x55, then 0xD5 (wire sequence 01,01,01,11). busy=1.
  - DATA: ready=1 only in the clock carrying dibit k=3 of the previous byte; the last SFD dibit counts as that clock for byte 0. The accepted byte's dibit 0 appears on tx in the next clock.
    - eop on the accepted byte: after its 4 dibits, go to PAD if bytes sent < MIN_FRAME, else FCS.
    - valid=0 in a ready clock is an underrun: txen=0 next clock, underrun pulses, go to IFG. The partial frame is discarded and no FCS is sent.
  - PAD: 0x00 bytes until MIN_FRAME bytes total; ready=0.
  - FCS: 4 bytes of ~CRC, least-significant byte first, each byte LSB dibit first. done pulses on the last FCS dibit clock. txen falls on the next clock.
  - IFG: txen=0, tx=0, busy=1 for IFG_BYTES*4 clocks, then IDLE. If valid is already high, the next preamble starts with no extra dead clock beyond the IDLE sample clock.
- CRC:
  - Algorithm: reflected CRC-32, polynomial 0xEDB88320, init 0xFFFFFFFF.
  - Coverage: updated 2 bits per clock over the data and pad dibits only; preamble and SFD are excluded.
  - Reload: reloaded to 0xFFFFFFFF on entry to PREAMBLE.
- TX_EN length for an N-byte frame: (PREAMBLE_BYTES+1+max(N,MIN_FRAME)+4)*4 consecutive clocks.
- Handshake rules:
  - data and eop are ignored when ready=0.
  - ready never asserts outside DATA.
  - ready never asserts twice within 4 clocks.
- Simultaneous events:
  - eop together with an underrun condition cannot occur; underrun is only detected at a ready clock where no byte is offered.
  - Reset overrides all other events.

Test Plan:
- MIN_FRAME=0, frame "123456789" (0x31..0x39) with valid held high:
  - Wire bytes: 7×0x55, 0xD5, data, then FCS 0x26 0x39 0xF4 0xCB.
  - txen high for exactly 84 clocks; done pulses once on the last of them.
  - Loop the output through eth_rmii_rx: sop/eop seen and bytes match.
- Default parameters, 14-byte frame:
  - 46 zero pad bytes follow the data.
  - txen high for 288 clocks.
  - FCS equals the CRC-32 of the 60-byte padded payload computed by the bench.
- Two 64-byte frames back to back with valid held high:
  - Between the falling txen of frame 1 and the rising txen of frame 2, txen is low for exactly 49 clocks (48 IFG clocks plus 1 IDLE sample clock).
  - busy stays high throughout the gap.
- Drop valid for one ready clock at byte 20:
  - underrun pulses; txen low the next clock; no FCS is sent.
  - busy stays high for 48 more clocks, then falls.
- Assert reset at clock 100 of a frame:
  - txen=0 and ready=0 on the next edge.
  - The following frame starts cleanly with a correct FCS.
- Random valid gaps only outside ready clocks, 277-byte frames, 5 packets:
  - The eth_rmii_rx loopback recovers all 5 frames byte-exact.
  - No underrun is reported.
